// File: rtl/ir_dir_pkg.sv
// Shared types and constants for the IR beam direction detector.
package ir_dir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        REV  = 2'd2,
        ERR  = 2'd3
    } ir_dir_state_t;

    localparam logic DIR_ASC  = 1'b1;
    localparam logic DIR_DESC = 1'b0;

    function automatic logic isBusy(input ir_dir_state_t s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/ir_debounce.sv
// One IR channel: 2-FF synchroniser, debouncer and registered rising-edge detect on the active level.
module ir_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic ir,
    output logic act,
    output logic hit
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic          actDly_reg;
    logic          hit_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            sync1_reg  <= 1'b1;
            sync2_reg  <= 1'b1;
            level_reg  <= 1'b1;
            actDly_reg <= 1'b0;
            hit_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg <= ir;
            sync2_reg <= sync1_reg;
            // Level only flips after DEBOUNCE consecutive disagreeing samples
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(DEBOUNCE - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
            actDly_reg <= ~level_reg;
            hit_reg    <= ~level_reg & ~actDly_reg;
        end
    end

    assign act = ~level_reg;
    assign hit = hit_reg;

endmodule

// File: rtl/ir_dir_detect.sv
// Direction detector: tracks the order of debounced beam hits and reports complete passes.
module ir_dir_detect
    import ir_dir_pkg::*;
#(
    parameter int N_SENS    = 3,
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 1000,
    parameter int EN_CYCLES = 16,
    parameter int CNT_W     = 16
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [N_SENS-1:0] IR,
    input  logic              SW,
    output logic              dir,
    output logic              en,
    output logic              valid,
    output logic              err,
    output logic              busy,
    output logic [CNT_W-1:0]  fwd_cnt,
    output logic [CNT_W-1:0]  rev_cnt
);

    localparam int EXP_W = $clog2(N_SENS);
    localparam int GAP_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int EN_W  = (EN_CYCLES > 0) ? $clog2(EN_CYCLES + 1) : 1;

    localparam logic [N_SENS-1:0] HIT_FIRST = N_SENS'(1);
    localparam logic [N_SENS-1:0] HIT_LAST  = HIT_FIRST << (N_SENS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TIMEOUT - 1);

    logic [N_SENS-1:0] act;
    logic [N_SENS-1:0] hitVec;

    for (genvar gi = 0; gi < N_SENS; gi++) begin : g_deb
        ir_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .CLK (CLK),
            .RSTn(RSTn),
            .ir  (IR[gi]),
            .act (act[gi]),
            .hit (hitVec[gi])
        );
    end

    ir_dir_state_t     state_reg, state_next;
    logic [EXP_W-1:0]  exp_reg, exp_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [EN_W-1:0]   enCnt_reg;
    logic [CNT_W-1:0]  fwdCnt_reg, revCnt_reg;
    logic              dir_reg, valid_reg, err_reg;
    logic              passDone, passDir, errSet;
    logic [N_SENS-1:0] expMask;
    logic [EXP_W-1:0]  termIdx;

    assign expMask = HIT_FIRST << exp_reg;
    assign termIdx = (state_reg == FWD) ? EXP_W'(N_SENS - 1) : '0;

    always_comb begin
        state_next = state_reg;
        exp_next   = exp_reg;
        gap_next   = gap_reg;
        passDone   = 1'b0;
        passDir    = DIR_ASC;
        errSet     = 1'b0;
        if (!SW) begin
            state_next = IDLE;
            gap_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    gap_next = '0;
                    if (hitVec == HIT_FIRST) begin
                        state_next = FWD;
                        exp_next   = EXP_W'(1);
                    end else if (hitVec == HIT_LAST) begin
                        state_next = REV;
                        exp_next   = EXP_W'(N_SENS - 2);
                    end else if (|hitVec) begin
                        state_next = ERR;
                        errSet     = 1'b1;
                    end
                end
                FWD, REV: begin
                    if (hitVec == expMask) begin
                        gap_next = '0;
                        if (exp_reg == termIdx) begin
                            passDone   = 1'b1;
                            passDir    = (state_reg == FWD) ? DIR_ASC : DIR_DESC;
                            state_next = IDLE;
                        end else begin
                            exp_next = (state_reg == FWD) ? exp_reg + EXP_W'(1)
                                                          : exp_reg - EXP_W'(1);
                        end
                    end else if ((|hitVec) || (gap_reg == GAP_LAST)) begin
                        state_next = ERR;
                        errSet     = 1'b1;
                    end else begin
                        gap_next = gap_reg + GAP_W'(1);
                    end
                end
                ERR: begin
                    // Hold until every beam is clear so a lingering object cannot restart a pass
                    gap_next = '0;
                    if (!(|act)) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_reg  <= IDLE;
            exp_reg    <= '0;
            gap_reg    <= '0;
            enCnt_reg  <= '0;
            fwdCnt_reg <= '0;
            revCnt_reg <= '0;
            dir_reg    <= 1'b0;
            valid_reg  <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            exp_reg   <= exp_next;
            gap_reg   <= gap_next;
            valid_reg <= passDone;
            err_reg   <= errSet;
            if (passDone) begin
                dir_reg <= passDir;
            end
            if (passDone && passDir == DIR_ASC && fwdCnt_reg != '1) begin
                fwdCnt_reg <= fwdCnt_reg + CNT_W'(1);
            end
            if (passDone && passDir == DIR_DESC && revCnt_reg != '1) begin
                revCnt_reg <= revCnt_reg + CNT_W'(1);
            end
            if (!SW) begin
                enCnt_reg <= '0;
            end else if (passDone) begin
                enCnt_reg <= EN_W'(EN_CYCLES);
            end else if (enCnt_reg != '0) begin
                enCnt_reg <= enCnt_reg - EN_W'(1);
            end
        end
    end

    assign dir     = dir_reg;
    assign en      = (enCnt_reg != '0);
    assign valid   = valid_reg;
    assign err     = err_reg;
    assign busy    = isBusy(state_reg);
    assign fwd_cnt = fwdCnt_reg;
    assign rev_cnt = revCnt_reg;

endmodule

// File: tb/tb_ir_dir_detect.sv
// Directed bench for ir_dir_detect: table of pulse scenarios plus hand-written corner sequences.
module tb_ir_dir_detect;

    logic        CLK  = 1'b0;
    logic        RSTn = 1'b0;
    logic        SW   = 1'b1;
    logic [2:0]  IR   = 3'b111;

    logic        dir, en, valid, err, busy;
    logic [15:0] fwdCnt, revCnt;
    logic        satDir, satEn, satValid, satErr, satBusy;
    logic [1:0]  satFwd, satRev;

    int passCnt  = 0;
    int totalCnt = 0;
    int expFwd   = 0;
    int expRev   = 0;

    always #5 CLK = ~CLK;

    ir_dir_detect #(
        .N_SENS(3), .DEBOUNCE(4), .TIMEOUT(64), .EN_CYCLES(16), .CNT_W(16)
    ) dut (
        .CLK(CLK), .RSTn(RSTn), .IR(IR), .SW(SW),
        .dir(dir), .en(en), .valid(valid), .err(err), .busy(busy),
        .fwd_cnt(fwdCnt), .rev_cnt(revCnt)
    );

    ir_dir_detect #(
        .N_SENS(3), .DEBOUNCE(4), .TIMEOUT(64), .EN_CYCLES(16), .CNT_W(2)
    ) dutSat (
        .CLK(CLK), .RSTn(RSTn), .IR(IR), .SW(SW),
        .dir(satDir), .en(satEn), .valid(satValid), .err(satErr), .busy(satBusy),
        .fwd_cnt(satFwd), .rev_cnt(satRev)
    );

    typedef struct {
        string name;
        int    start0, start1, start2, len;
        int    expValid, expErr, expEn, expBusy;
        int    dFwd, dRev, expDir;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int required);
        totalCnt++;
        if (actual == required) passCnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, required);
    endtask

    task automatic runVec(input vec_t v);
        int nValid = 0, nErr = 0, nEn = 0, nBusy = 0;
        int st[3];
        st = '{v.start0, v.start1, v.start2};
        for (int c = 0; c < 150; c++) begin
            for (int k = 0; k < 3; k++)
                IR[k] = !(st[k] >= 0 && c >= st[k] && c < st[k] + v.len);
            tick();
            nValid += int'(valid);
            nErr   += int'(err);
            nEn    += int'(en);
            nBusy  += int'(busy);
        end
        expFwd += v.dFwd;
        expRev += v.dRev;
        $display("vec %s: valid=%0d err=%0d en=%0d busy=%0d dir=%0b fwd=%0d rev=%0d",
                 v.name, nValid, nErr, nEn, nBusy, dir, fwdCnt, revCnt);
        check({v.name, " valid"}, nValid, v.expValid);
        check({v.name, " err"}, nErr, v.expErr);
        check({v.name, " en_cycles"}, nEn, v.expEn);
        check({v.name, " busy_seen"}, int'(nBusy > 0), v.expBusy);
        check({v.name, " busy_end"}, int'(busy), 0);
        check({v.name, " dir"}, int'(dir), v.expDir);
        check({v.name, " fwd_cnt"}, int'(fwdCnt), expFwd);
        check({v.name, " rev_cnt"}, int'(revCnt), expRev);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nValid, nErr, busyRise, errAt;
        int satExp[5];

        vecs[0] = '{"asc",          1,  4,  8, 13, 1, 0, 16, 1, 1, 0, 1};
        vecs[1] = '{"desc",         8,  4,  1, 13, 1, 0, 16, 1, 0, 1, 0};
        vecs[2] = '{"ir1_first",   -1,  1, -1, 13, 0, 1,  0, 1, 0, 0, 0};
        vecs[3] = '{"simul_0_2",    1, -1,  1, 13, 0, 1,  0, 1, 0, 0, 0};
        vecs[4] = '{"glitch3",      1, -1, -1,  3, 0, 0,  0, 0, 0, 0, 0};
        vecs[5] = '{"pulse4",       1, -1, -1,  4, 0, 1,  0, 1, 0, 0, 0};
        vecs[6] = '{"timeout",      1, -1, -1, 13, 0, 1,  0, 1, 0, 0, 0};
        vecs[7] = '{"out_of_order", 1, -1,  4, 13, 0, 1,  0, 1, 0, 0, 0};
        vecs[8] = '{"asc_again",    1,  4,  8, 13, 1, 0, 16, 1, 1, 0, 1};
        satExp  = '{1, 2, 3, 3, 3};

        // Reset state
        repeat (3) tick();
        check("reset outputs", int'({dir, en, valid, err, busy}), 0);
        check("reset counters", int'(fwdCnt) + int'(revCnt), 0);
        check("reset sat outputs", int'({satDir, satEn, satValid, satErr, satBusy, satFwd, satRev}), 0);
        RSTn = 1'b1;
        repeat (3) tick();

        for (int i = 0; i < 9; i++) runVec(vecs[i]);

        // Timeout latency: err follows FSM entry into FWD by exactly TIMEOUT cycles
        busyRise = -1;
        errAt    = -1;
        for (int c = 0; c < 200; c++) begin
            IR[0] = !(c >= 1 && c < 14);
            tick();
            if (busy && busyRise < 0) busyRise = c;
            if (err && errAt < 0) errAt = c;
        end
        $display("seq timeout_latency: busy_rise=%0d err_at=%0d", busyRise, errAt);
        check("timeout found", int'(busyRise >= 0 && errAt >= 0), 1);
        check("timeout latency", errAt - busyRise, 64);

        // ERR holds while a beam stays broken; hits during ERR are ignored
        nValid = 0;
        nErr   = 0;
        for (int c = 0; c < 60; c++) begin
            IR[1] = !(c >= 1 && c < 41);
            IR[0] = !(c >= 20 && c < 33);
            tick();
            nValid += int'(valid);
            nErr   += int'(err);
            if (c == 39) check("err_hold busy while blocked", int'(busy), 1);
        end
        $display("seq err_hold: valid=%0d err=%0d busy=%0b", nValid, nErr, busy);
        check("err_hold err pulses", nErr, 1);
        check("err_hold valid", nValid, 0);
        check("err_hold back to idle", int'(busy), 0);

        // Disarm after the IR1 hit discards the pass silently
        nValid = 0;
        nErr   = 0;
        for (int c = 0; c < 80; c++) begin
            IR[0] = !(c >= 1 && c < 14);
            IR[1] = !(c >= 4 && c < 17);
            IR[2] = !(c >= 20 && c < 33);
            SW    = !(c >= 16 && c < 40);
            tick();
            nValid += int'(valid);
            nErr   += int'(err);
            if (c == 15) check("disarm busy before", int'(busy), 1);
            if (c == 17) check("disarm busy after", int'(busy), 0);
        end
        $display("seq disarm: valid=%0d err=%0d fwd=%0d rev=%0d", nValid, nErr, fwdCnt, revCnt);
        check("disarm valid", nValid, 0);
        check("disarm err", nErr, 0);
        check("disarm fwd_cnt", int'(fwdCnt), expFwd);
        check("disarm rev_cnt", int'(revCnt), expRev);

        // SW low during an en run clears en on the next cycle, dir and counters hold
        for (int c = 0; c < 60; c++) begin
            IR[0] = !(c >= 1 && c < 14);
            IR[1] = !(c >= 4 && c < 17);
            IR[2] = !(c >= 8 && c < 21);
            SW    = !(c >= 20 && c < 30);
            tick();
            if (c == 19) check("en_clear en before", int'(en), 1);
            if (c == 20) check("en_clear en after", int'(en), 0);
        end
        expFwd++;
        $display("seq en_clear: en=%0b dir=%0b fwd=%0d", en, dir, fwdCnt);
        check("en_clear dir hold", int'(dir), 1);
        check("en_clear fwd_cnt", int'(fwdCnt), expFwd);

        // Reset mid-pass
        for (int c = 0; c < 50; c++) begin
            IR[0] = !(c >= 1 && c < 14);
            IR[1] = !(c >= 4 && c < 17);
            IR[2] = 1'b1;
            RSTn  = !(c >= 14 && c < 30);
            tick();
            if (c == 13) check("mid_reset busy before", int'(busy), 1);
            if (c == 15) begin
                check("mid_reset outputs", int'({dir, en, valid, err, busy}), 0);
                check("mid_reset counters", int'(fwdCnt) + int'(revCnt), 0);
            end
        end
        expFwd = 0;
        expRev = 0;
        $display("seq mid_reset: busy=%0b fwd=%0d rev=%0d", busy, fwdCnt, revCnt);
        check("mid_reset idle after", int'(busy), 0);

        // Saturation with a 2-bit counter
        for (int p = 0; p < 5; p++) begin
            runVec(vecs[0]);
            $display("seq sat pass %0d: sat_fwd=%0d", p + 1, satFwd);
            check($sformatf("sat fwd_cnt pass %0d", p + 1), int'(satFwd), satExp[p]);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
